isqrt_share_arbiter: RTL and testbench

- Shares one external pipelined isqrt instance among N_REQ independent requesters.
- Arbitration is round-robin, with at most one issue per cycle.
- A requester-ID tag travels alongside each operand in a valid-qualified shift pipeline matched to the isqrt latency. Each result is routed back to the requester that issued it.
- Lets formula blocks with low per-source rate use one isqrt instead of one per source.

---
 rtl/isqrt_arb_pkg.sv | 8 +
 rtl/isqrt_share_arbiter_rr_arbiter.sv | 23 ++
 rtl/isqrt_share_arbiter.sv | 65 ++++++
 tb/tb_isqrt_share_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/isqrt_arb_pkg.sv
// isqrt_arb_pkg: shared defaults, requester-id width helper and id type for the isqrt share arbiter
package isqrt_arb_pkg;
  localparam int N_REQ_DEF = 4;
  function automatic int id_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
  typedef logic [id_w(N_REQ_DEF)-1:0] req_id_t;
endpackage

// File: rtl/isqrt_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick (req, ptr -> one-hot gnt, idx) searching upward from ptr with wrap
module rr_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int N = N_REQ_DEF,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N] = 1'b1;
        idx = IW'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/isqrt_share_arbiter.sv
// isqrt_share_arbiter: round-robin sharing of one pipelined isqrt (req_vld/req_x/req_rdy in, sq_x_vld/sq_x out, sq_y_vld/sq_y in, rsp_vld/rsp_y/err out; sticky tag check when ISQRT_SHARE_ARBITER_CHECK_EN is defined)
module isqrt_share_arbiter
  import isqrt_arb_pkg::*;
#(
  parameter int width = 32,
  parameter int N_REQ = N_REQ_DEF,
  parameter int ISQRT_LATENCY = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*width-1:0] req_x,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   sq_x_vld,
  output logic [width-1:0]       sq_x,
  input  logic                   sq_y_vld,
  input  logic [width-1:0]       sq_y,
  output logic [N_REQ-1:0]       rsp_vld,
  output logic [width-1:0]       rsp_y,
  output logic                   err
);
  localparam int IW = id_w(N_REQ);
  localparam int L = ISQRT_LATENCY;
  logic [IW-1:0] ptr, gnt_idx, iss_id;
  logic [N_REQ-1:0] gnt;
  logic [L-1:0] tag_vld;
  logic [IW-1:0] tag_id [L];
  logic xfer;
  rr_arbiter #(.N(N_REQ)) u_arb (.req(req_vld), .ptr(ptr), .gnt(gnt), .idx(gnt_idx));
  assign req_rdy = gnt;
  assign xfer = |gnt;
  always_ff @(posedge clk)
    if (rst) begin
      sq_x_vld <= 1'b0;
      rsp_vld <= '0;
      ptr <= '0;
      tag_vld <= '0;
    end else begin
      sq_x_vld <= xfer;
      tag_vld <= (tag_vld << 1) | L'(sq_x_vld);
      rsp_vld <= sq_y_vld && tag_vld[L-1] ? N_REQ'(1) << tag_id[L-1] : '0;
      if (xfer) ptr <= gnt_idx == IW'(N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  // data registers only move when their qualifier is set, so idle cycles hold them
  always_ff @(posedge clk) begin
    if (xfer) begin
      sq_x <= req_x[gnt_idx*width +: width];
      iss_id <= gnt_idx;
    end
    if (sq_x_vld) tag_id[0] <= iss_id;
    for (int k = 1; k < L; k++)
      if (tag_vld[k-1]) tag_id[k] <= tag_id[k-1];
    if (sq_y_vld) rsp_y <= sq_y;
  end
`ifdef ISQRT_SHARE_ARBITER_CHECK_EN
  always_ff @(posedge clk)
    if (rst) err <= 1'b0;
    else if (sq_y_vld != tag_vld[L-1]) begin
      err <= 1'b1;
      if (!err) $error("isqrt_share_arbiter: sq_y_vld disagrees with tag pipeline");
    end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_isqrt_share_arbiter.sv
// tb_isqrt_share_arbiter: randomized scoreboard bench for isqrt_share_arbiter with a behavioural pipelined isqrt
module tb_isqrt_share_arbiter;
  localparam int W = 32;
  localparam int N = 4;
  localparam int L = 16;
  typedef struct {int id; logic [W-1:0] y; int due;} ent_t;
  logic clk = 0, rst = 1, inject = 0, exp_err = 0;
  logic [N-1:0] req_vld = '0, req_rdy, rsp_vld;
  logic [N*W-1:0] req_x = '0;
  logic sq_x_vld, sq_y_vld, err;
  logic [W-1:0] sq_x, sq_y, rsp_y;
  logic [L-1:0] mv = '0;
  logic [W-1:0] my [L];
  int checks = 0, failures = 0, cyc = 0;
  ent_t q[$];
  int mptr, idx;
  logic [N-1:0] eg;
  bit pv, have_x, have_y, prev_sy, exp_now;
  logic [W-1:0] px, hx, last_y;

  isqrt_share_arbiter #(.width(W), .N_REQ(N), .ISQRT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x), .req_rdy(req_rdy),
    .sq_x_vld(sq_x_vld), .sq_x(sq_x), .sq_y_vld(sq_y_vld), .sq_y(sq_y),
    .rsp_vld(rsp_vld), .rsp_y(rsp_y), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    logic [W-1:0] r = '0;
    longint unsigned t;
    for (int b = 15; b >= 0; b--) begin
      t = longint'(r | (32'd1 << b));
      if (t * t <= longint'(x)) r = r | (32'd1 << b);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_x();
    int s = $urandom_range(3);
    logic [W-1:0] r = $urandom_range(65535);
    return s == 0 ? $urandom : s == 1 ? r * r : s == 2 ? 32'd100 : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s at cycle %0d: got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  // external isqrt stand-in: fixed latency L, floor(sqrt(x))
  always @(posedge clk) begin
`ifdef ISQRT_SHARE_ARBITER_CHECK_EN
    if (rst) mv <= '0;
    else
`endif
    mv <= {mv[L-2:0], sq_x_vld};
    my[0] <= isqrt(sq_x);
    for (int k = 1; k < L; k++) my[k] <= my[k-1];
  end
  assign sq_y_vld = mv[L-1] | inject;
  assign sq_y = my[L-1];

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      mptr = 0;
      q.delete();
      pv = 0;
      have_x = 0;
      have_y = 0;
    end else begin
      eg = '0;
      idx = 0;
      for (int k = 0; k < N; k++)
        if (req_vld[(mptr + k) % N]) begin
          idx = (mptr + k) % N;
          eg[idx] = 1'b1;
          break;
        end
      chk(req_rdy == eg, "grant", W'(req_rdy), W'(eg));
      chk(sq_x_vld == pv, "sq_x_vld", W'(sq_x_vld), W'(pv));
      if (pv) chk(sq_x == px, "sq_x", sq_x, px);
      else if (have_x) chk(sq_x == hx, "sq_x_hold", sq_x, hx);
      chk(err == exp_err, "err", W'(err), W'(exp_err));
      exp_now = q.size() > 0 && q[0].due == cyc;
      if (exp_now) begin
        chk(rsp_vld == N'(1) << q[0].id, "rsp_vld", W'(rsp_vld), W'(N'(1) << q[0].id));
        chk(rsp_y == q[0].y, "rsp_y", rsp_y, q[0].y);
        last_y = q[0].y;
        have_y = 1;
        void'(q.pop_front());
      end else begin
        if (rsp_vld != '0) chk(0, "unexpected_rsp_vld", W'(rsp_vld), '0);
        else if (prev_sy) have_y = 0;
        else if (have_y) chk(rsp_y == last_y, "rsp_y_hold", rsp_y, last_y);
      end
      if (pv) begin
        hx = px;
        have_x = 1;
      end
      pv = |eg;
      if (|eg) begin
        px = req_x[idx*W +: W];
        q.push_back(ent_t'{idx, isqrt(px), cyc + L + 2});
        mptr = (idx + 1) % N;
      end
    end
    prev_sy = sq_y_vld;
  end

  task automatic step(input logic [N-1:0] mask, input int pct);
    logic [N-1:0] g;
    @(negedge clk);
    g = req_vld & req_rdy;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (!req_vld[i] || g[i]) begin
        req_vld[i] = mask[i] && ($urandom_range(99) < pct);
        req_x[i*W +: W] = rnd_x();
      end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1;
    req_vld = '0;
    exp_err = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic drain();
    repeat (L + 6) step('0, 0);
    chk(q.size() == 0, "drained", W'(q.size()), '0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) step('0, 0);
    req_vld[2] = 1;
    req_x[2*W +: W] = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k < 10) req_x[2*W +: W] = k * k;
      else req_vld[2] = 0;
    end
    drain();
    do_reset();
    repeat (24) step(4'hF, 100);
    drain();
    step(4'b0010, 100);
    repeat (12) step(4'b1010, 100);
    drain();
    repeat (60) step(4'hF, 30);
    drain();
    do_reset();
    repeat (3) step(4'b0101, 100);
    repeat (5) step('0, 0);
    do_reset();
    repeat (L + 4) step('0, 0);
    step(4'b1001, 100);
    drain();
    repeat (300) step(4'hF, 60);
    drain();
`ifdef ISQRT_SHARE_ARBITER_CHECK_EN
    @(posedge clk);
    #1 inject = 1;
    @(posedge clk);
    #1 inject = 0;
    exp_err = 1;
    repeat (5) step('0, 0);
    do_reset();
    repeat (3) step('0, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
